// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - RX pulse inputs and buffered frame stream of uart_rx_frame_ctrl
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_p_data;
  logic                  rx_data_valid;
  logic                  rx_parity_error;
  logic                  rx_stop_error;
  logic                  rx_start_glitch;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  // master: the RX datapath plus the frame consumer; slave: the controller
  modport master (
    output rx_p_data, rx_data_valid, rx_parity_error, rx_stop_error, rx_start_glitch,
    output out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  rx_p_data, rx_data_valid, rx_parity_error, rx_stop_error, rx_start_glitch,
    input  out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART RX frame sequencer with config shadow, frame FIFO and error status
// Optional stuck-frame watchdog is built when RX_TIMEOUT_EN is defined.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH       = 8,
  parameter int PRESCALE_WIDTH   = 6,
  parameter int DEFAULT_PRESCALE = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int ERR_CNT_WIDTH    = 8
) (
  input  logic                          rx_clk,
  input  logic                          rst_n,
  input  logic                          rx_in,
  input  logic [PRESCALE_WIDTH-1:0]     cfg_prescale,
  input  logic                          cfg_parity_enable,
  input  logic                          cfg_parity_type,
  input  logic                          cfg_update,
  uart_rx_frame_ctrl_if.slave           frame,
  output logic [PRESCALE_WIDTH-1:0]     prescale,
  output logic                          parity_enable,
  output logic                          parity_type,
  output logic                          cfg_pending,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [3:0]                    err_status,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt,
  input  logic                          status_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;
  logic   rx_prev;
  logic   fall, rx_exit, timeout;
  logic   enter_busy, enter_idle;

  assign fall    = rx_prev & ~rx_in;
  assign rx_exit = frame.rx_data_valid | frame.rx_stop_error | frame.rx_start_glitch;
  assign busy    = (state == BUSY);

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rx_prev <= 1'b1;
    end else begin
      state   <= state_next;
      rx_prev <= rx_in;
    end
  end

  always_comb begin
    state_next = state;
    enter_busy = 1'b0;
    enter_idle = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_next = BUSY;
          enter_busy = 1'b1;
        end
      end
      BUSY: begin
        if (rx_exit || timeout) begin
          state_next = IDLE;
          enter_idle = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef RX_TIMEOUT_EN
  localparam int WD_W = PRESCALE_WIDTH + 4;

  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_limit;

  // Fires on the last allowed BUSY cycle so the FSM has spent exactly wd_limit cycles in BUSY
  assign wd_limit = WD_W'(prescale) * WD_W'(DATA_WIDTH + 3);
  assign timeout  = (state == BUSY) && !rx_exit && (prescale != '0) &&
                    ((wd_cnt + WD_W'(1)) == wd_limit);

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n)
      wd_cnt <= '0;
    else if (state == BUSY)
      wd_cnt <= wd_cnt + WD_W'(1);
    else
      wd_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  logic [PRESCALE_WIDTH-1:0] sh_prescale;
  logic                      sh_parity_enable;
  logic                      sh_parity_type;
  logic                      cfg_direct;

  // A request arriving on the IDLE-entry cycle is newer than the shadow, so it goes straight out
  assign cfg_direct = cfg_update && (((state == IDLE) && !enter_busy) || enter_idle);

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale         <= PRESCALE_WIDTH'(DEFAULT_PRESCALE);
      parity_enable    <= 1'b0;
      parity_type      <= 1'b0;
      cfg_pending      <= 1'b0;
      sh_prescale      <= PRESCALE_WIDTH'(DEFAULT_PRESCALE);
      sh_parity_enable <= 1'b0;
      sh_parity_type   <= 1'b0;
    end else if (cfg_direct) begin
      prescale         <= cfg_prescale;
      parity_enable    <= cfg_parity_enable;
      parity_type      <= cfg_parity_type;
      cfg_pending      <= 1'b0;
    end else if (enter_idle && cfg_pending) begin
      prescale         <= sh_prescale;
      parity_enable    <= sh_parity_enable;
      parity_type      <= sh_parity_type;
      cfg_pending      <= 1'b0;
    end else if (cfg_update) begin
      sh_prescale      <= cfg_prescale;
      sh_parity_enable <= cfg_parity_enable;
      sh_parity_type   <= cfg_parity_type;
      cfg_pending      <= 1'b1;
    end
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  full, push_req, push, pop;

  assign full            = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign push_req        = frame.rx_data_valid & ~frame.rx_parity_error & ~frame.rx_stop_error;
  assign pop             = frame.out_valid & frame.out_ready;
  assign push            = push_req & (~full | pop);
  assign frame.out_valid = (fifo_count != '0);
  assign frame.out_data  = mem[rd_ptr];

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= frame.rx_p_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  logic [3:0] err_set;
  logic       err_inc;

  assign err_set = {push_req & full & ~pop, timeout, frame.rx_stop_error, frame.rx_parity_error};
  assign err_inc = |err_set;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_status <= '0;
      err_cnt    <= '0;
    end else if (status_clr) begin
      err_status <= err_set;
      err_cnt    <= err_inc ? ERR_CNT_WIDTH'(1) : '0;
    end else begin
      err_status <= err_status | err_set;
      if (err_inc && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Controller that sequences the UART receive datapath in the rx_clk domain.
- Owns the RX configuration (prescale, parity enable/type). Changes are applied only between frames, never mid-frame.
- Tracks frame activity from the line and the RX completion/error pulses, with a watchdog on stuck frames.
- Buffers good frames in a small FIFO with a valid/ready output.
- Keeps sticky error status and a saturating error count for the register block.

Parameters:
DATA_WIDTH, 8, frame payload width; matches RX p_data.
PRESCALE_WIDTH, 6, width of the prescale field.
DEFAULT_PRESCALE, 8, prescale value applied at reset.
FIFO_DEPTH, 4, frame buffer entries; power of two, minimum 2.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
rx_clk  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
rx_in  in  1  serial line, same net that feeds the RX
cfg_prescale  in  PRESCALE_WIDTH  requested prescale
cfg_parity_enable  in  1  requested parity enable
cfg_parity_type  in  1  requested parity type (0 even, 1 odd)
cfg_update  in  1  one-cycle pulse: capture the cfg_* inputs
rx_p_data  in  DATA_WIDTH  RX parallel data
rx_data_valid  in  1  RX frame-complete pulse
rx_parity_error  in  1  RX parity error pulse
rx_stop_error  in  1  RX stop error pulse
rx_start_glitch  in  1  RX start glitch pulse
prescale  out  PRESCALE_WIDTH  applied prescale, to RX
parity_enable  out  1  applied parity enable, to RX
parity_type  out  1  applied parity type, to RX
cfg_pending  out  1  a captured config is waiting for IDLE
busy  out  1  FSM in BUSY
out_data  out  DATA_WIDTH  FIFO head
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts the head
fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
err_status  out  4  sticky {overflow, timeout, stop, parity}
err_cnt  out  ERR_CNT_WIDTH  saturating count of bad frames
status_clr  in  1  clears err_status and err_cnt

Behaviour:
- Reset values (asynchronous, all registered):
  - prescale=DEFAULT_PRESCALE; parity_enable=0; parity_type=0.
  - cfg_pending=0; FSM=IDLE; busy=0; FIFO empty (out_valid=0, fifo_count=0).
  - out_data=0; err_status=0; err_cnt=0; line history register=1.
- FSM states: IDLE and BUSY.
  - IDLE→BUSY: registered rx_in was 1 and current rx_in is 0 (falling edge).
  - BUSY→IDLE: any of rx_data_valid, rx_stop_error, rx_start_glitch, or timeout.
  - If an exit event and a falling edge occur in the same cycle, the exit wins; the new edge is detected from the next cycle.
- Config handling:
  - cfg_update in IDLE with no BUSY entry that cycle: the cfg_* values are applied on the outputs the next cycle.
  - Otherwise the values are captured into a shadow and cfg_pending=1. The shadow is applied, and cfg_pending cleared, on the cycle the FSM enters IDLE.
  - A later cfg_update while pending overwrites the shadow.
- Frame push:
  - Push rx_p_data when rx_data_valid=1, rx_parity_error=0 and rx_stop_error=0.
  - A flagged frame is never pushed. Its error sets the matching err_status bit and increments err_cnt by 1.
  - rx_start_glitch returns the FSM to IDLE only; no count, no status bit.
- FIFO:
  - Pop on out_valid && out_ready; out_data shows the head with zero-latency (first-word-fall-through).
  - Push when full without a pop: data dropped, err_status[3] set, err_cnt+1.
  - Push and pop in the same cycle when full: both happen and the count is unchanged.
  - Push into empty: out_valid=1 on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- err_cnt saturates at all-ones.
- status_clr: if a set or increment event coincides with the clear, the event wins. err_status holds that bit only, and err_cnt reads 1.

Optional Feature:
Macro RX_TIMEOUT_EN.
- Defined: a watchdog counter of width PRESCALE_WIDTH+4 runs in BUSY and clears on IDLE entry.
  - When the count reaches prescale*(DATA_WIDTH+3), the FSM returns to IDLE, err_status[2] is set and err_cnt increments.
  - prescale=0 disables the timeout.
- Undefined: no counter is built and err_status[2] is tied to 0. BUSY exits only on RX pulses.

Test Plan:
- Reset: after rst_n deassert → prescale=8, parity_enable=0, busy=0, out_valid=0, err_status=0.
- Good frame: falling edge on rx_in, then rx_data_valid with rx_p_data=0xA5 → busy drops, out_valid=1, out_data=0xA5, fifo_count=1. Pop with out_ready=1 → empty.
- Config mid-frame: in BUSY, cfg_update with prescale=16 → cfg_pending=1, prescale still 8. On the rx_data_valid exit → prescale=16, cfg_pending=0.
- Overflow: push 5 frames (0x01..0x05) with out_ready=0 → fifo_count=4, err_status[3]=1, err_cnt=1. Pops return 0x01..0x04.
- Errors and saturation: rx_data_valid with rx_parity_error → no push, err_status[0]=1. 300 stop errors with ERR_CNT_WIDTH=8 → err_cnt=255. status_clr coinciding with a stop error → err_status=0b0010, err_cnt=1.
- Timeout (RX_TIMEOUT_EN defined, prescale=8): falling edge, then no RX pulse → exactly 88 BUSY cycles later the FSM is IDLE and err_status[2]=1.
